// File: rtl/isp_cam_pkg.sv
// Shared types and constants for the two-camera frame arbiter.
package isp_cam_pkg;

  // Arbiter states: waiting for enable, waiting for a start-of-frame, forwarding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } arb_state_e;

  // cfg_mode encodings.
  localparam logic [1:0] MODE_CAM0  = 2'd0;
  localparam logic [1:0] MODE_CAM1  = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;
  localparam logic [1:0] MODE_FIRST = 2'd3;

  localparam int DEF_DW = 10;

  // Candidate while armed: the fixed-camera modes pin it, the others keep
  // whatever the arbiter last chose.
  function automatic logic arm_candidate(input logic [1:0] mode, input logic cur);
    case (mode)
      MODE_CAM0: arm_candidate = 1'b0;
      MODE_CAM1: arm_candidate = 1'b1;
      default:   arm_candidate = cur;
    endcase
  endfunction

endpackage

// File: rtl/isp_vsync_edge.sv
// Per-camera VSYNC edge detector: registers vsync and flags its rising
// (start-of-frame) and falling (end-of-frame) edges in the same cycle the
// edge appears on the input.
module isp_vsync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic sof,
  output logic eof
);

  logic vsync_q;

  // Previous-cycle copy of vsync.
  always_ff @(posedge clk) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync;
  end

  assign sof = vsync & ~vsync_q;
  assign eof = ~vsync & vsync_q;

endmodule

// File: rtl/isp_cam_frame_arbiter.sv
// Frame-granular arbiter sharing one ISP input between two cameras. The grant
// only changes on frame boundaries, so the ISP always sees whole frames.
module isp_cam_frame_arbiter
  import isp_cam_pkg::*;
#(
  parameter int                   DW        = DEF_DW,
  parameter int                   TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd5_000_000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cfg_en,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_err_clr,
  input  logic [1:0]    cam_vsync,
  input  logic [1:0]    cam_hsync,
  input  logic [1:0]    cam_valid,
  input  logic [2*DW-1:0] cam_data,
  output logic          isp_vsync,
  output logic          isp_hsync,
  output logic          isp_valid,
  output logic [DW-1:0] isp_data,
  output logic          isp_src,
  output logic          busy,
  output logic [15:0]   frame_cnt0,
  output logic [15:0]   frame_cnt1,
  output logic          irq_frame_done,
  output logic          err_timeout
);

  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT - 1'b1;

  arb_state_e             state_q, state_d;
  logic                   cand_q, cand_d;
  logic                   src_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;

  logic [1:0]             sof, eof;
  logic [1:0][DW-1:0]     cam_pix;
  logic                   arm_cand;
  logic                   win_vld, win_sel;
  logic                   grant, frame_end, wdog_fire;
  logic                   fwd, sel;

  assign cam_pix = cam_data;

  for (genvar k = 0; k < 2; k++) begin : g_edge
    isp_vsync_edge u_edge (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .vsync (cam_vsync[k]),
      .sof   (sof[k]),
      .eof   (eof[k])
    );
  end

  // Pick the camera that would win a grant this cycle while armed.
  always_comb begin
    arm_cand = arm_candidate(cfg_mode, cand_q);
    win_vld  = 1'b0;
    win_sel  = arm_cand;
    if (cfg_mode == MODE_FIRST) begin
      win_vld = |sof;
      win_sel = ~sof[0];   // CAM0 takes ties
    end else begin
      win_vld = sof[arm_cand];
    end
  end

  // FSM next-state, candidate and watchdog.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    src_d     = isp_src;
    wdog_d    = wdog_q;
    grant     = 1'b0;
    frame_end = 1'b0;
    wdog_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d = ARM;
          wdog_d  = '0;
          cand_d  = (cfg_mode == MODE_CAM1);
        end
      end
      ARM: begin
        if (!cfg_en) begin
          state_d = IDLE;
        end else if (win_vld) begin
          state_d = STREAM;
          src_d   = win_sel;
          cand_d  = arm_cand;
          wdog_d  = '0;
          grant   = 1'b1;
        end else if (wdog_q == WDOG_LAST) begin
          wdog_fire = 1'b1;
          wdog_d    = '0;
          cand_d    = (cfg_mode == MODE_ALT) ? ~arm_cand : arm_cand;
        end else begin
          wdog_d = wdog_q + 1'b1;
          cand_d = arm_cand;
        end
      end
      STREAM: begin
        if (eof[isp_src]) begin
          frame_end = 1'b1;
          state_d   = cfg_en ? ARM : IDLE;
          wdog_d    = '0;
          case (cfg_mode)
            MODE_ALT:  cand_d = ~isp_src;
            MODE_CAM0: cand_d = 1'b0;
            MODE_CAM1: cand_d = 1'b1;
            default:   cand_d = cand_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The SOF cycle of the winner is forwarded too, so the ISP sees the edge.
  assign fwd  = (state_q == STREAM) || grant;
  assign sel  = (state_q == STREAM) ? isp_src : win_sel;
  assign busy = (state_q == STREAM);

  // State, candidate, grant and watchdog registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cand_q  <= 1'b0;
      isp_src <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      isp_src <= src_d;
      wdog_q  <= wdog_d;
    end
  end

  // Registered output mux; zero whenever nothing is granted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !fwd) begin
      isp_vsync <= 1'b0;
      isp_hsync <= 1'b0;
      isp_valid <= 1'b0;
      isp_data  <= '0;
    end else begin
      isp_vsync <= cam_vsync[sel];
      isp_hsync <= cam_hsync[sel];
      isp_valid <= cam_valid[sel];
      isp_data  <= cam_pix[sel];
    end
  end

  // Frame counters, frame-done pulse and sticky timeout flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_cnt0     <= '0;
      frame_cnt1     <= '0;
      irq_frame_done <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      irq_frame_done <= frame_end;
      if (frame_end && !isp_src) frame_cnt0 <= frame_cnt0 + 1'b1;
      if (frame_end &&  isp_src) frame_cnt1 <= frame_cnt1 + 1'b1;
      if (wdog_fire)        err_timeout <= 1'b1;
      else if (cfg_err_clr) err_timeout <= 1'b0;
    end
  end

endmodule
